// File: rtl/hazard_detection_unit.sv
// Hazard detection for the MIPS pipeline: a three-slot in-flight scoreboard (EXE/MEM/WB)
// that drives freeze/bubble controls and a saturating stall-cycle counter.
module hazard_detection_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_uses_src2,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              has_forwarding,
  input  logic              branch_taken,
  output logic              freeze,
  output logic              bubble,
  output logic [ADDR_W-1:0] exe_dest,
  output logic [ADDR_W-1:0] mem_dest,
  output logic [ADDR_W-1:0] wb_dest,
  output logic              exe_wb_en,
  output logic              mem_wb_en,
  output logic              wb_wb_en,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic              exe_valid_q, exe_valid_d;
  logic [ADDR_W-1:0] exe_dest_q, exe_dest_d;
  logic              exe_wb_en_q, exe_wb_en_d;
  logic              exe_mem_r_en_q, exe_mem_r_en_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic              mem_wb_en_q, mem_wb_en_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic              wb_wb_en_q, wb_wb_en_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic exe_hit;
  logic mem_hit;
  logic hazard;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic v, input logic w,
                                     input logic [ADDR_W-1:0] d,
                                     input logic [ADDR_W-1:0] r);
    return v && w && (d == r) && (r != '0);
  endfunction

  function automatic logic src_hit(input logic v, input logic w,
                                   input logic [ADDR_W-1:0] d,
                                   input logic [ADDR_W-1:0] s1,
                                   input logic [ADDR_W-1:0] s2,
                                   input logic use2);
    return reg_match(v, w, d, s1) || (use2 && reg_match(v, w, d, s2));
  endfunction

  // With forwarding only a load in EXE stalls; without it any EXE/MEM producer does.
  always_comb begin
    exe_hit = src_hit(exe_valid_q, exe_wb_en_q, exe_dest_q, id_src1, id_src2, id_uses_src2);
    mem_hit = src_hit(mem_valid_q, mem_wb_en_q, mem_dest_q, id_src1, id_src2, id_uses_src2);
    if (has_forwarding) begin
      hazard = exe_hit && exe_mem_r_en_q;
    end else begin
      hazard = exe_hit || mem_hit;
    end
    freeze = id_valid && hazard && !branch_taken;
    bubble = freeze || branch_taken;
  end

  always_comb begin
    wb_valid_d  = mem_valid_q;
    wb_dest_d   = mem_dest_q;
    wb_wb_en_d  = mem_wb_en_q;
    mem_valid_d = exe_valid_q;
    mem_dest_d  = exe_dest_q;
    mem_wb_en_d = exe_wb_en_q;
    exe_valid_d    = 1'b0;
    exe_dest_d     = '0;
    exe_wb_en_d    = 1'b0;
    exe_mem_r_en_d = 1'b0;
    if (id_valid && !bubble) begin
      exe_valid_d    = 1'b1;
      exe_dest_d     = id_dest;
      exe_wb_en_d    = id_wb_en;
      exe_mem_r_en_d = id_mem_r_en;
    end
    stall_cycles_d = stall_cycles_q;
    if (freeze && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_valid_q    <= 1'b0;
      exe_dest_q     <= '0;
      exe_wb_en_q    <= 1'b0;
      exe_mem_r_en_q <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_dest_q     <= '0;
      mem_wb_en_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_dest_q      <= '0;
      wb_wb_en_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      exe_valid_q    <= exe_valid_d;
      exe_dest_q     <= exe_dest_d;
      exe_wb_en_q    <= exe_wb_en_d;
      exe_mem_r_en_q <= exe_mem_r_en_d;
      mem_valid_q    <= mem_valid_d;
      mem_dest_q     <= mem_dest_d;
      mem_wb_en_q    <= mem_wb_en_d;
      wb_valid_q     <= wb_valid_d;
      wb_dest_q      <= wb_dest_d;
      wb_wb_en_q     <= wb_wb_en_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign exe_dest     = exe_dest_q;
  assign mem_dest     = mem_dest_q;
  assign wb_dest      = wb_dest_q;
  assign exe_wb_en    = exe_wb_en_q && exe_valid_q;
  assign mem_wb_en    = mem_wb_en_q && mem_valid_q;
  assign wb_wb_en     = wb_wb_en_q && wb_valid_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed test-plan scenarios followed by
// random traffic, all compared against an instruction-level pipeline model.
module tb_hazard_detection_unit;

  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [ADDR_W-1:0] id_src1;
  logic [ADDR_W-1:0] id_src2;
  logic              id_uses_src2;
  logic [ADDR_W-1:0] id_dest;
  logic              id_wb_en;
  logic              id_mem_r_en;
  logic              has_forwarding;
  logic              branch_taken;
  logic              freeze;
  logic              bubble;
  logic [ADDR_W-1:0] exe_dest;
  logic [ADDR_W-1:0] mem_dest;
  logic [ADDR_W-1:0] wb_dest;
  logic              exe_wb_en;
  logic              mem_wb_en;
  logic              wb_wb_en;
  logic [CNT_W-1:0]  stall_cycles;

  hazard_detection_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src2(id_uses_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .has_forwarding(has_forwarding),
    .branch_taken(branch_taken), .freeze(freeze), .bubble(bubble),
    .exe_dest(exe_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in-flight instructions listed by age, index 0 = the one just past ID.
  typedef struct {
    bit     valid;
    int     dest;
    bit     writes;
    bit     is_load;
  } instr_t;

  instr_t inflight[3];
  int     model_stalls;
  bit     exp_freeze;
  bit     exp_bubble;
  int     total;
  int     bad;

  task automatic chk(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic bit reads_reg(input int r);
    return (r != 0) && ((r == int'(id_src1)) || (id_uses_src2 && r == int'(id_src2)));
  endfunction

  // A producer at distance 0 (EXE) or 1 (MEM) is still unresolved; forwarding
  // leaves only a load at distance 0 unresolved.
  function automatic bit model_hazard();
    bit h = 0;
    for (int age = 0; age < 2; age++) begin
      if (inflight[age].valid && inflight[age].writes && reads_reg(inflight[age].dest)) begin
        if (!has_forwarding || (age == 0 && inflight[age].is_load)) h = 1;
      end
    end
    return h;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) inflight[i] = '{0, 0, 0, 0};
    model_stalls = 0;
  endtask

  task automatic modelAdvance();
    if (exp_freeze && model_stalls < CNT_MAX) model_stalls++;
    inflight[2] = inflight[1];
    inflight[1] = inflight[0];
    if (id_valid && !exp_bubble)
      inflight[0] = '{1, int'(id_dest), id_wb_en, id_mem_r_en};
    else
      inflight[0] = '{0, 0, 0, 0};
  endtask

  task automatic applyStimulus(input bit v, input int s1, input int s2, input bit u2,
                               input int dst, input bit wb, input bit ld,
                               input bit fwd, input bit br);
    id_valid       = v;
    id_src1        = ADDR_W'(s1);
    id_src2        = ADDR_W'(s2);
    id_uses_src2   = u2;
    id_dest        = ADDR_W'(dst);
    id_wb_en       = wb;
    id_mem_r_en    = ld;
    has_forwarding = fwd;
    branch_taken   = br;
  endtask

  task automatic checkOutput(input string tag);
    exp_freeze = id_valid && model_hazard() && !branch_taken;
    exp_bubble = exp_freeze || branch_taken;
    chk({tag, ".freeze"}, int'(freeze), int'(exp_freeze));
    chk({tag, ".bubble"}, int'(bubble), int'(exp_bubble));
    chk({tag, ".exe_dest"}, int'(exe_dest), inflight[0].dest);
    chk({tag, ".mem_dest"}, int'(mem_dest), inflight[1].dest);
    chk({tag, ".wb_dest"}, int'(wb_dest), inflight[2].dest);
    chk({tag, ".exe_wb_en"}, int'(exe_wb_en), int'(inflight[0].valid && inflight[0].writes));
    chk({tag, ".mem_wb_en"}, int'(mem_wb_en), int'(inflight[1].valid && inflight[1].writes));
    chk({tag, ".wb_wb_en"}, int'(wb_wb_en), int'(inflight[2].valid && inflight[2].writes));
    chk({tag, ".stall_cycles"}, int'(stall_cycles), model_stalls);
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic step(input string tag);
    #1;
    checkOutput(tag);
    modelAdvance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit fwd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, fwd, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle(1);
    modelReset();

    // Reset state
    doReset();
    step("reset");
    #1;
    chk("reset.stall_zero", int'(stall_cycles), 0);

    // Load r3 then add r4,r3,r1 with forwarding: single freeze cycle
    applyStimulus(1, 1, 2, 0, 3, 1, 1, 1, 0);
    step("lu.load");
    applyStimulus(1, 3, 1, 1, 4, 1, 0, 1, 0);
    #1;
    chk("lu.freeze_on", int'(freeze), 1);
    chk("lu.bubble_on", int'(bubble), 1);
    step("lu.add1");
    #1;
    chk("lu.freeze_off", int'(freeze), 0);
    chk("lu.exe_empty", int'(exe_wb_en), 0);
    chk("lu.stall_one", int'(stall_cycles), 1);
    step("lu.add2");
    idle(1);
    step("lu.drain");

    // addi r3 then add r4,r3,r1 without forwarding: two freeze cycles
    doReset();
    applyStimulus(1, 1, 0, 0, 3, 1, 0, 0, 0);
    step("nf.addi");
    applyStimulus(1, 3, 1, 1, 4, 1, 0, 0, 0);
    #1;
    chk("nf.freeze_c1", int'(freeze), 1);
    step("nf.add1");
    #1;
    chk("nf.freeze_c2", int'(freeze), 1);
    step("nf.add2");
    #1;
    chk("nf.freeze_c3", int'(freeze), 0);
    step("nf.add3");
    idle(0);
    #1;
    chk("nf.exe_dest", int'(exe_dest), 4);
    chk("nf.exe_wb_en", int'(exe_wb_en), 1);
    chk("nf.stalls", int'(stall_cycles), 2);
    step("nf.idle");

    // Register zero never matches, either mode
    for (int m = 0; m < 2; m++) begin
      doReset();
      applyStimulus(1, 1, 0, 0, 0, 1, 1, bit'(m), 0);
      step("r0.prod");
      applyStimulus(1, 0, 0, 1, 6, 1, 0, bit'(m), 0);
      #1;
      chk("r0.freeze_exe", int'(freeze), 0);
      step("r0.cons1");
      step("r0.cons2");
    end

    // Branch flush wins over a load-use hazard
    doReset();
    applyStimulus(1, 1, 0, 0, 5, 1, 1, 1, 0);
    step("br.load");
    applyStimulus(1, 5, 5, 1, 7, 1, 0, 1, 1);
    #1;
    chk("br.freeze", int'(freeze), 0);
    chk("br.bubble", int'(bubble), 1);
    step("br.flush");
    idle(1);
    #1;
    chk("br.exe_empty", int'(exe_wb_en), 0);
    chk("br.stall_same", int'(stall_cycles), 0);
    step("br.after");

    // Chain of r7 <- r7 without forwarding keeps freezing well past saturation
    doReset();
    for (int i = 0; i < 36; i++) begin
      applyStimulus(1, 7, 7, 1, 7, 1, 0, 0, 0);
      step("sat.chain");
    end
    #1;
    chk("sat.hold", int'(stall_cycles), CNT_MAX);

    // Asynchronous reset during a no-forwarding stall
    doReset();
    applyStimulus(1, 1, 0, 0, 3, 1, 0, 0, 0);
    step("ar.addi");
    applyStimulus(1, 3, 0, 0, 4, 1, 0, 0, 0);
    step("ar.stall1");
    #1;
    chk("ar.freeze_before", int'(freeze), 1);
    rst = 1'b0;
    #1;
    modelReset();
    chk("ar.freeze", int'(freeze), 0);
    chk("ar.stall", int'(stall_cycles), 0);
    chk("ar.exe_wb_en", int'(exe_wb_en), 0);
    chk("ar.exe_dest", int'(exe_dest), 0);
    checkOutput("ar.all");
    @(negedge clk);
    rst = 1'b1;

    // Random traffic over a small register range to provoke frequent hits
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 8), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 4), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 9) == 0));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Producer-side companion of the forwarding logic in the MIPS pipeline. It holds a three-slot scoreboard of in-flight instructions (EXE, MEM, WB) and exports each slot's destination and write-back enable to the forwarding unit. It compares the ID-stage sources against the scoreboard and generates freeze and bubble controls for the IF/ID and ID/EXE registers. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface

- ADDR_W, 5, register address width
- CNT_W, 16, stall counter width
- clk  input  1  pipeline clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- id_valid  input  1  ID stage holds a real instruction
- id_src1, id_src2  input  ADDR_W  ID source registers
- id_uses_src2  input  1  src2 is read (R-type or store value)
- id_dest  input  ADDR_W  ID destination register
- id_wb_en  input  1  ID instruction writes the register file
- id_mem_r_en  input  1  ID instruction is a load
- has_forwarding  input  1  forwarding enabled
- branch_taken  input  1  flush the ID instruction this cycle
- freeze  output  1  hold PC and IF/ID
- bubble  output  1  load NOP into ID/EXE
- exe_dest, mem_dest, wb_dest  output  ADDR_W  slot destinations
- exe_wb_en, mem_wb_en, wb_wb_en  output  1  slot write-back enables, gated by slot valid
- stall_cycles  output  CNT_W  count of cycles with freeze=1

## Operation

**Scoreboard**
- Each slot holds {valid, dest, wb_en, mem_r_en}.
- On every clock:
  - WB <= MEM
  - MEM <= EXE
  - EXE <= ID fields if (id_valid && !bubble); otherwise EXE <= empty (all fields 0).
- There is no freeze path for EXE/MEM/WB. Those slots always advance.

**Match rule**
- match(slot, r) = slot.valid && slot.wb_en && slot.dest == r && r != 0.
- src_hit(slot) = match(slot, id_src1) || (id_uses_src2 && match(slot, id_src2)).

**Hazard**
- has_forwarding=1: hazard = src_hit(EXE) && EXE.mem_r_en. This is load-use only.
- has_forwarding=0: hazard = src_hit(EXE) || src_hit(MEM).
- The WB slot never causes a hazard. The register file writes in the first half-cycle.

**Controls**
- freeze = id_valid && hazard && !branch_taken
- bubble = freeze || branch_taken
- branch_taken has priority over hazard. The flushed instruction never freezes.

**Exported slot fields**
- Slot fields are driven straight from the slot registers.
- The *_wb_en outputs are ANDed with the slot's valid bit.

**stall_cycles**
- Increments by 1 on each clock edge where freeze=1.
- Saturates at all-ones and does not wrap.

## Timing

**Reset (rst=0, asynchronous)**
- All slots are cleared to empty.
- stall_cycles = 0.
- All exported slot outputs are 0.
- freeze and bubble are 0 while id_valid=0.
- Reset asserted mid-stall clears the scoreboard immediately. freeze drops in the same cycle, combinationally.

**Latency**
- freeze and bubble are combinational from the ID inputs and the registered slots, within the same cycle.
- Slot contents update one clock after the instruction is accepted.

**Stall lengths**
- Load-use with forwarding: exactly 1 freeze cycle. The load then moves to MEM and forwarding resolves it.
- Dependency with no forwarding:
  - 2 freeze cycles if the producer is in EXE.
  - 1 freeze cycle if the producer is in MEM.
- While frozen, the ID inputs are held by the stage. The hazard is re-evaluated every cycle against the advancing slots.

**Boundary conditions**
- r == 0 never matches.
- When src1 == src2, count a single hit.
- A simultaneous hit in EXE and MEM produces one freeze per cycle until both clear.
- has_forwarding changes take effect in the same cycle.

## Test plan

- Reset, then load r3 followed by add r4,r3,r1 with has_forwarding=1 -> freeze=1 for exactly 1 cycle; bubble=1 that cycle; stall_cycles=1; EXE empty the cycle after the freeze.
- Same add after addi r3 with has_forwarding=0 -> freeze for 2 consecutive cycles, then the add enters EXE; exe_dest=4 and exe_wb_en=1 one clock later.
- Producer dest=0 and consumer src1=0, in both modes -> freeze stays 0.
- Load r5 with dependent ID instruction and branch_taken=1 in the same cycle -> freeze=0, bubble=1, EXE empty next cycle, stall_cycles unchanged.
- Force 2^CNT_W+3 freeze cycles (CNT_W=4 build) -> stall_cycles holds 4'hF and does not wrap.
- rst=0 asserted during a no-forwarding stall -> freeze=0, all slot outputs 0, and stall_cycles=0 immediately, without waiting for a clock edge.
